// File: rtl/vta_pkg.sv
// Shared VTA definitions: instruction field layout, opcodes and the
// compute-stage FSM encoding.
package vta_pkg;

  localparam int INS_WIDTH = 128;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_STORE  = 3'd1;
  localparam logic [2:0] OP_GEMM   = 3'd2;
  localparam logic [2:0] OP_FINISH = 3'd3;
  localparam logic [2:0] OP_ALU    = 3'd4;

  localparam int OPCODE_LSB     = 0;
  localparam int OPCODE_W       = 3;
  localparam int POP_PREV_BIT   = 3;
  localparam int POP_NEXT_BIT   = 4;
  localparam int PUSH_PREV_BIT  = 5;
  localparam int PUSH_NEXT_BIT  = 6;
  localparam int RESET_REG_BIT  = 7;
  localparam int UOP_BGN_LSB    = 8;
  localparam int UOP_BGN_W      = 13;
  localparam int UOP_END_LSB    = 21;
  localparam int UOP_END_W      = 14;
  localparam int ITER_OUT_LSB   = 35;
  localparam int ITER_IN_LSB    = 49;
  localparam int ITER_W         = 14;
  localparam int DST_FACTOR_LSB = 63;
  localparam int SRC_FACTOR_LSB = 85;
  localparam int WGT_FACTOR_LSB = 107;
  localparam int FACTOR_W       = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DEP,
    ST_EXEC,
    ST_WAIT_DONE,
    ST_PUSH
  } ctrl_state_e;

  typedef struct packed {
    logic [2:0] opcode;
    logic       pop_prev;
    logic       pop_next;
    logic       push_prev;
    logic       push_next;
  } insn_hdr_t;

  function automatic insn_hdr_t decode_hdr(input logic [INS_WIDTH-1:0] insn);
    insn_hdr_t hdr;
    hdr.opcode    = insn[OPCODE_LSB +: OPCODE_W];
    hdr.pop_prev  = insn[POP_PREV_BIT];
    hdr.pop_next  = insn[POP_NEXT_BIT];
    hdr.push_prev = insn[PUSH_PREV_BIT];
    hdr.push_next = insn[PUSH_NEXT_BIT];
    return hdr;
  endfunction

endpackage

// File: rtl/dep_token_counter.sv
// Saturating dependency-token counter with a sticky overflow flag.
module dep_token_counter #(
  parameter int TOK_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic ovf
);

  logic [TOK_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc && !dec) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign nonzero = |cnt_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/gemm_compute_ctrl.sv
// Compute-stage controller: accepts VTA instructions, resolves load/store
// dependency tokens and sequences the gemm core through start/done.
module gemm_compute_ctrl #(
  parameter int INS_WIDTH  = vta_pkg::INS_WIDTH,
  parameter int TOK_WIDTH  = 4,
  parameter int PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  insn_valid,
  input  logic [INS_WIDTH-1:0]  insn_data,
  output logic                  insn_ready,
  input  logic                  l2g_dep_valid,
  input  logic                  s2g_dep_valid,
  output logic                  g2l_dep_valid,
  output logic                  g2s_dep_valid,
  output logic [INS_WIDTH-1:0]  gemm_insn,
  output logic                  gemm_start,
  input  logic                  gemm_done,
  output logic                  busy,
  output logic                  finish,
  output logic                  tok_ovf,
  output logic [PERF_WIDTH-1:0] retired_cnt
);
  import vta_pkg::*;

  ctrl_state_e           state_q, state_d;
  logic [INS_WIDTH-1:0]  insn_q, insn_d;
  logic [PERF_WIDTH-1:0] retired_q, retired_d;
  insn_hdr_t             hdr;
  logic                  l2g_dec, s2g_dec;
  logic                  l2g_nz, s2g_nz, l2g_ovf, s2g_ovf;
  logic                  deps_ok;

  dep_token_counter #(.TOK_WIDTH(TOK_WIDTH)) u_l2g_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (l2g_dep_valid),
    .dec     (l2g_dec),
    .nonzero (l2g_nz),
    .ovf     (l2g_ovf)
  );

  dep_token_counter #(.TOK_WIDTH(TOK_WIDTH)) u_s2g_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (s2g_dep_valid),
    .dec     (s2g_dec),
    .nonzero (s2g_nz),
    .ovf     (s2g_ovf)
  );

  assign hdr     = decode_hdr(insn_q[vta_pkg::INS_WIDTH-1:0]);
  assign deps_ok = (!hdr.pop_prev || l2g_nz) && (!hdr.pop_next || s2g_nz);

  always_comb begin
    state_d       = state_q;
    insn_d        = insn_q;
    retired_d     = retired_q;
    l2g_dec       = 1'b0;
    s2g_dec       = 1'b0;
    insn_ready    = 1'b0;
    g2l_dep_valid = 1'b0;
    g2s_dep_valid = 1'b0;
    gemm_start    = 1'b0;
    finish        = 1'b0;
    gemm_insn     = '0;
    unique case (state_q)
      ST_IDLE: begin
        insn_ready = 1'b1;
        if (insn_valid) begin
          insn_d  = insn_data;
          state_d = ST_WAIT_DEP;
        end
      end
      ST_WAIT_DEP: begin
        // Both required tokens are consumed in the same cycle, never one alone.
        if (deps_ok) begin
          l2g_dec = hdr.pop_prev;
          s2g_dec = hdr.pop_next;
          state_d = (hdr.opcode == OP_GEMM) ? ST_EXEC : ST_PUSH;
        end
      end
      ST_EXEC: begin
        gemm_start = 1'b1;
        gemm_insn  = insn_q;
        state_d    = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        gemm_insn = insn_q;
        if (gemm_done) state_d = ST_PUSH;
      end
      ST_PUSH: begin
        g2l_dep_valid = hdr.push_prev;
        g2s_dep_valid = hdr.push_next;
        finish        = (hdr.opcode == OP_FINISH);
        retired_d     = retired_q + 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset silences every decoded output, including pulses of an aborted op.
    if (rst) begin
      insn_ready    = 1'b0;
      g2l_dep_valid = 1'b0;
      g2s_dep_valid = 1'b0;
      gemm_start    = 1'b0;
      finish        = 1'b0;
      gemm_insn     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      insn_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      insn_q    <= insn_d;
      retired_q <= retired_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign tok_ovf     = l2g_ovf | s2g_ovf;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_gemm_compute_ctrl.sv
// Directed bench for gemm_compute_ctrl: latency, dependency tokens,
// saturation, concurrent inc/dec, FINISH and reset abort.
module tb_gemm_compute_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         insn_valid;
  logic [127:0] insn_data;
  logic         insn_ready;
  logic         l2g_dep_valid, s2g_dep_valid;
  logic         g2l_dep_valid, g2s_dep_valid;
  logic [127:0] gemm_insn;
  logic         gemm_start, gemm_done;
  logic         busy, finish, tok_ovf;
  logic [31:0]  retired_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] INSN_A = 128'hCAFE_F00D_1234_5678_9ABC_DEF0_1357_9B0A;
  localparam logic [127:0] INSN_B = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3262;
  localparam logic [127:0] INSN_C = 128'hAAAA_5555_0F0F_F0F0_1111_2222_3333_4402;

  gemm_compute_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .insn_valid    (insn_valid),
    .insn_data     (insn_data),
    .insn_ready    (insn_ready),
    .l2g_dep_valid (l2g_dep_valid),
    .s2g_dep_valid (s2g_dep_valid),
    .g2l_dep_valid (g2l_dep_valid),
    .g2s_dep_valid (g2s_dep_valid),
    .gemm_insn     (gemm_insn),
    .gemm_start    (gemm_start),
    .gemm_done     (gemm_done),
    .busy          (busy),
    .finish        (finish),
    .tok_ovf       (tok_ovf),
    .retired_cnt   (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in the current cycle; returns in cycle 1.
  task automatic issue(input logic [127:0] insn);
    insn_data  = insn;
    insn_valid = 1'b1;
    tick();
    insn_valid = 1'b0;
    insn_data  = '0;
  endtask

  initial begin
    rst = 1'b1; insn_valid = 1'b0; insn_data = '0;
    l2g_dep_valid = 1'b0; s2g_dep_valid = 1'b0; gemm_done = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_ready", insn_ready, 1'b0);
    check("rst_outs", {busy, gemm_start, finish, g2l_dep_valid, g2s_dep_valid, tok_ovf}, 6'b0);
    check("rst_insn", gemm_insn, 128'h0);
    check("rst_retired", retired_cnt, 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", {insn_ready, busy}, 2'b10);

    // NOP, no deps: PUSH at cycle 2, ready at cycle 3
    issue(128'h0);
    check("nop_c1", {busy, insn_ready}, 2'b10);
    tick();
    check("nop_c2_push", {busy, g2l_dep_valid, g2s_dep_valid, finish}, 4'b1000);
    check("nop_c2_retired", retired_cnt, 32'd0);
    tick();
    check("nop_c3", {busy, insn_ready}, 2'b01);
    check("nop_retired", retired_cnt, 32'd1);

    // GEMM waiting on an l2g token
    issue(INSN_A);
    for (int i = 0; i < 10; i++) begin
      check("gemm_hold", {busy, gemm_start, gemm_insn == 128'h0}, 3'b101);
      tick();
    end
    l2g_dep_valid = 1'b1;
    tick();
    l2g_dep_valid = 1'b0;
    check("gemm_tok_reg", gemm_start, 1'b0);
    tick();
    check("gemm_start", gemm_start, 1'b1);
    check("gemm_insn_exec", gemm_insn, INSN_A);
    tick();
    check("gemm_start_once", gemm_start, 1'b0);
    check("gemm_insn_wait", gemm_insn, INSN_A);
    tick();
    gemm_done = 1'b1;
    tick();
    gemm_done = 1'b0;
    check("gemm_push", {busy, g2l_dep_valid, g2s_dep_valid}, 3'b100);
    check("gemm_insn_push", gemm_insn, 128'h0);
    tick();
    check("gemm_retired", {insn_ready, retired_cnt}, {1'b1, 32'd2});

    // GEMM with push_prev and push_next, done 5 cycles after start
    issue(INSN_B);
    tick();
    check("push_start", gemm_start, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("push_quiet", {gemm_start, g2l_dep_valid, g2s_dep_valid, busy}, 4'b0001);
    end
    gemm_done = 1'b1;
    tick();
    gemm_done = 1'b0;
    check("push_pulses", {g2l_dep_valid, g2s_dep_valid}, 2'b11);
    tick();
    check("push_width", {g2l_dep_valid, g2s_dep_valid}, 2'b00);
    check("push_retired", {insn_ready, retired_cnt}, {1'b1, 32'd3});

    // Token saturation: 16 pulses into a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      l2g_dep_valid = 1'b1;
      tick();
      if (i == 14) check("sat_no_ovf_at_15", tok_ovf, 1'b0);
    end
    l2g_dep_valid = 1'b0;
    check("sat_ovf", tok_ovf, 1'b1);
    for (int j = 0; j < 15; j++) begin
      issue(128'h08);
      tick();
      tick();
      check("sat_nostall", insn_ready, 1'b1);
    end
    check("sat_retired", retired_cnt, 32'd18);
    issue(128'h08);
    repeat (6) tick();
    check("sat_16th_stall", {busy, insn_ready, retired_cnt}, {2'b10, 32'd18});
    l2g_dep_valid = 1'b1;
    tick();
    l2g_dep_valid = 1'b0;
    tick();
    check("sat_release_push", {busy, retired_cnt}, {1'b1, 32'd18});
    tick();
    check("sat_release_done", {insn_ready, retired_cnt, tok_ovf}, {1'b1, 32'd19, 1'b1});

    // Concurrent increment and decrement with count=1
    l2g_dep_valid = 1'b1;
    tick();
    l2g_dep_valid = 1'b0;
    issue(128'h08);
    l2g_dep_valid = 1'b1;
    tick();
    l2g_dep_valid = 1'b0;
    tick();
    check("conc_retired", {insn_ready, retired_cnt}, {1'b1, 32'd20});
    issue(128'h08);
    tick();
    tick();
    check("conc_count_kept", {insn_ready, retired_cnt}, {1'b1, 32'd21});
    issue(128'h08);
    repeat (3) tick();
    check("conc_now_empty", {busy, insn_ready}, 2'b10);
    l2g_dep_valid = 1'b1;
    tick();
    l2g_dep_valid = 1'b0;
    tick();
    tick();
    check("conc_release", {insn_ready, retired_cnt}, {1'b1, 32'd22});

    // FINISH: one-cycle finish pulse
    issue(128'h03);
    check("fin_c1", finish, 1'b0);
    tick();
    check("fin_pulse", finish, 1'b1);
    tick();
    check("fin_width", {finish, insn_ready, retired_cnt}, {2'b01, 32'd23});

    // Reset in WAIT_DONE aborts the GEMM and clears counters
    s2g_dep_valid = 1'b1;
    tick();
    s2g_dep_valid = 1'b0;
    issue(INSN_C);
    tick();
    check("rmid_start", {gemm_start, gemm_insn}, {1'b1, INSN_C});
    tick();
    tick();
    check("rmid_waitdone", {busy, gemm_insn}, {1'b1, INSN_C});
    rst = 1'b1;
    tick();
    check("rmid_outs", {insn_ready, busy, gemm_start, finish, g2l_dep_valid, g2s_dep_valid, tok_ovf}, 7'b0);
    check("rmid_insn", gemm_insn, 128'h0);
    check("rmid_retired", retired_cnt, 32'd0);
    rst = 1'b0;
    gemm_done = 1'b1;
    tick();
    gemm_done = 1'b0;
    check("rmid_late_done", {busy, g2l_dep_valid, g2s_dep_valid, finish}, 4'b0000);
    tick();
    check("rmid_no_retire", {insn_ready, retired_cnt}, {1'b1, 32'd0});
    issue(128'h10);
    repeat (4) tick();
    check("rmid_s2g_cleared", {busy, retired_cnt}, {1'b1, 32'd0});
    s2g_dep_valid = 1'b1;
    tick();
    s2g_dep_valid = 1'b0;
    tick();
    tick();
    check("rmid_recover", {insn_ready, retired_cnt}, {1'b1, 32'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
